// File: rtl/wb_cache_ctrl_pkg.sv
// Shared types and default geometry for the write-back cache controller.
// The optional CACHE_STATS_EN build adds hit/miss counters in the top module.
package wb_cache_ctrl_pkg;

    localparam int unsigned WordW          = 32;
    localparam int unsigned LineAddrLenDef = 3;
    localparam int unsigned SetAddrLenDef  = 3;
    localparam int unsigned TagAddrLenDef  = 5;
    localparam int unsigned LineWordsDef   = 1 << LineAddrLenDef;
    localparam int unsigned MemAddrLenDef  = TagAddrLenDef + SetAddrLenDef;

    typedef enum logic [1:0] {
        StIdle,
        StSwapOut,
        StSwapIn,
        StSwapInOk
    } cache_state_e;

    typedef logic [LineWordsDef-1:0][WordW-1:0] line_t;

endpackage

// File: rtl/wb_cache_ctrl_if.sv
// Line-transfer bus between the cache (master) and main memory (slave).
interface wb_cache_ctrl_if #(
    parameter int unsigned MEM_ADDR_LEN = 8,
    parameter int unsigned LINE_WORDS   = 8
) ();

    logic [MEM_ADDR_LEN-1:0]      mem_addr;
    logic                         mem_rd_req;
    logic                         mem_wr_req;
    logic [LINE_WORDS-1:0][31:0]  mem_wr_line;
    logic [LINE_WORDS-1:0][31:0]  mem_rd_line;
    logic                         mem_gnt;

    modport master (
        output mem_addr,
        output mem_rd_req,
        output mem_wr_req,
        output mem_wr_line,
        input  mem_rd_line,
        input  mem_gnt
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_req,
        input  mem_wr_req,
        input  mem_wr_line,
        output mem_rd_line,
        output mem_gnt
    );

endinterface

// File: rtl/wb_cache_ctrl_mem_line_requester.sv
// Miss-handling FSM: evicts a dirty victim line, then fetches the missing line.
// A request rises only once mem_addr has been stable for a cycle and drops the cycle after gnt.
module wb_cache_ctrl_mem_line_requester
    import wb_cache_ctrl_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LineAddrLenDef,
    parameter int unsigned SET_ADDR_LEN  = SetAddrLenDef,
    parameter int unsigned TAG_ADDR_LEN  = TagAddrLenDef
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [TAG_ADDR_LEN-1:0]                    req_tag,
    input  logic [SET_ADDR_LEN-1:0]                    req_set,
    input  logic                                       victim_dirty,
    input  logic [TAG_ADDR_LEN-1:0]                    victim_tag,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][WordW-1:0]   victim_line,
    output logic                                       busy,
    output logic                                       evict_done,
    output logic                                       fill_en,
    output logic [SET_ADDR_LEN-1:0]                    line_set,
    output logic [TAG_ADDR_LEN-1:0]                    line_tag,
    output logic [(1<<LINE_ADDR_LEN)-1:0][WordW-1:0]   fill_line,
    wb_cache_ctrl_if.master                            mem
);

    localparam int unsigned MemAddrLen = TAG_ADDR_LEN + SET_ADDR_LEN;
    localparam int unsigned LineWords  = 1 << LINE_ADDR_LEN;

    typedef logic [LineWords-1:0][WordW-1:0] line_words_t;

    cache_state_e            state_q, state_d;
    logic                    armed_q, armed_d;
    logic [MemAddrLen-1:0]   mem_addr_q, mem_addr_d;
    line_words_t             wr_line_q, wr_line_d;
    logic [TAG_ADDR_LEN-1:0] tag_q, tag_d;
    logic [SET_ADDR_LEN-1:0] set_q, set_d;
    logic                    gnt_taken;
    logic                    rd_req_out;
    logic                    wr_req_out;

    // A grant only counts while our request is actually on the bus.
    assign gnt_taken = armed_q & mem.mem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            mem_addr_q <= '0;
            wr_line_q  <= '0;
            tag_q      <= '0;
            set_q      <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            mem_addr_q <= mem_addr_d;
            wr_line_q  <= wr_line_d;
            tag_q      <= tag_d;
            set_q      <= set_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        wr_line_d  = wr_line_q;
        tag_d      = tag_q;
        set_d      = set_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tag_d = req_tag;
                    set_d = req_set;
                    if (victim_dirty) begin
                        state_d    = StSwapOut;
                        mem_addr_d = {victim_tag, req_set};
                        wr_line_d  = victim_line;
                    end else begin
                        state_d    = StSwapIn;
                        mem_addr_d = {req_tag, req_set};
                    end
                end
            end
            StSwapOut: begin
                if (gnt_taken) begin
                    state_d    = StSwapIn;
                    mem_addr_d = {tag_q, set_q};
                end
            end
            StSwapIn: begin
                if (gnt_taken) begin
                    state_d = StSwapInOk;
                end
            end
            StSwapInOk: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // Arm one cycle after every state entry so mem_addr is settled before req rises.
        armed_d = (state_d == state_q) && (state_q != StIdle);
    end

    always_comb begin
        busy       = (state_q != StIdle);
        wr_req_out = (state_q == StSwapOut) && armed_q;
        rd_req_out = (state_q == StSwapIn) && armed_q;
        evict_done = (state_q == StSwapOut) && gnt_taken;
        fill_en    = (state_q == StSwapInOk);
    end

    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wr_line = wr_line_q;
    assign mem.mem_rd_req  = rd_req_out;
    assign mem.mem_wr_req  = wr_req_out;
    assign line_set        = set_q;
    assign line_tag        = tag_q;
    assign fill_line       = mem.mem_rd_line;

endmodule

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache: tag/data arrays and hit logic.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module wb_cache_ctrl
    import wb_cache_ctrl_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LineAddrLenDef,
    parameter int unsigned SET_ADDR_LEN  = SetAddrLenDef,
    parameter int unsigned TAG_ADDR_LEN  = TagAddrLenDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [WordW-1:0]  wr_data,
    output logic [WordW-1:0]  rd_data,
    output logic              miss,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    wb_cache_ctrl_if.master   mem
);

    localparam int unsigned Sets      = 1 << SET_ADDR_LEN;
    localparam int unsigned LineWords = 1 << LINE_ADDR_LEN;
    localparam int unsigned SetLo     = LINE_ADDR_LEN + 2;
    localparam int unsigned TagLo     = SetLo + SET_ADDR_LEN;
    localparam int unsigned TagHi     = TagLo + TAG_ADDR_LEN - 1;

    typedef logic [LineWords-1:0][WordW-1:0] line_words_t;

    logic [LINE_ADDR_LEN-1:0] req_off;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic                     unused_addr;

    assign req_off     = addr[SetLo-1:2];
    assign req_set     = addr[TagLo-1:SetLo];
    assign req_tag     = addr[TagHi:TagLo];
    assign unused_addr = ^{addr[1:0], addr[31:TagHi+1]};

    line_words_t             data_q [Sets];
    line_words_t             data_d [Sets];
    logic [TAG_ADDR_LEN-1:0] tag_q  [Sets];
    logic [TAG_ADDR_LEN-1:0] tag_d  [Sets];
    logic [Sets-1:0]         valid_q, valid_d;
    logic [Sets-1:0]         dirty_q, dirty_d;
    logic [WordW-1:0]        rd_data_q, rd_data_d;

    logic                    req;
    logic                    hit;
    logic                    busy;
    logic                    accept;
    logic                    start;
    logic                    evict_done;
    logic                    fill_en;
    logic [SET_ADDR_LEN-1:0] line_set;
    logic [TAG_ADDR_LEN-1:0] line_tag;
    line_words_t             fill_line;

    assign req    = rd_req | wr_req;
    // Valid gates the compare so an all-zero tag in an empty line never hits.
    assign hit    = valid_q[req_set] && (tag_q[req_set] == req_tag);
    assign miss   = req & (busy | ~hit);
    assign accept = req & ~miss;
    assign start  = req & ~busy & ~hit;

    wb_cache_ctrl_mem_line_requester #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_requester (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .req_tag      (req_tag),
        .req_set      (req_set),
        .victim_dirty (valid_q[req_set] & dirty_q[req_set]),
        .victim_tag   (tag_q[req_set]),
        .victim_line  (data_q[req_set]),
        .busy         (busy),
        .evict_done   (evict_done),
        .fill_en      (fill_en),
        .line_set     (line_set),
        .line_tag     (line_tag),
        .fill_line    (fill_line),
        .mem          (mem)
    );

    always_comb begin
        data_d    = data_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        rd_data_d = rd_data_q;
        if (accept) begin
            if (wr_req) begin
                data_d[req_set][req_off] = wr_data;
                dirty_d[req_set]         = 1'b1;
            end else begin
                rd_data_d = data_q[req_set][req_off];
            end
        end
        if (evict_done) begin
            dirty_d[line_set] = 1'b0;
        end
        if (fill_en) begin
            data_d[line_set]  = fill_line;
            tag_d[line_set]   = line_tag;
            valid_d[line_set] = 1'b1;
            dirty_d[line_set] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            dirty_q   <= '0;
            rd_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Array contents are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign rd_data = rd_data_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        missed_q, missed_d;

    // The held request is accepted after its fill; missed_q keeps that from counting as a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        missed_d   = missed_q;
        if (!req) begin
            missed_d = 1'b0;
        end
        if (start) begin
            missed_d = 1'b1;
            if (miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
        if (accept) begin
            missed_d = 1'b0;
            if (!missed_q && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            missed_q   <= missed_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
